// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter.
// Takes a WIDTH-bit word over a valid/ready handshake and shifts it out one
// bit per clock on s_out, qualified by s_valid.
// done marks the cycle that carries the last bit of each word.
// A word offered while the last bit is on the line is loaded on that same
// edge, so consecutive words leave as one gap-free bit stream.
module piso_shift_tx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] p_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             s_out,
   output logic             s_valid,
   output logic             busy,
   output logic             done
);

   localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic             at_last;
   logic             accept;

   // Bit-order dependent views of the word.
   logic             first_bit;
   logic             next_bit;
   logic [WIDTH-1:0] sr_shifted;

   assign at_last = (state == SHIFT) && (cnt == LAST);
   assign accept  = load_valid && load_ready;

   // Pick the first bit of a new word and the follow-on bit/shift for the order.
   always_comb begin
      first_bit  = 1'b0;
      next_bit   = 1'b0;
      sr_shifted = '0;
      if (MSB_FIRST) begin
         first_bit  = p_in[WIDTH-1];
         next_bit   = sr[WIDTH-2];
         sr_shifted = {sr[WIDTH-2:0], 1'b0};
      end else begin
         first_bit  = p_in[0];
         next_bit   = sr[1];
         sr_shifted = {1'b0, sr[WIDTH-1:1]};
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next state: enter SHIFT on a load; fall back to IDLE only after the last bit with no new word.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (at_last && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs, decoded from registers only (load_ready never looks at load_valid).
   always_comb begin
      load_ready = (state == IDLE) || at_last;
      busy       = (state == SHIFT);
      done       = s_valid && (cnt == LAST);
   end

   // Datapath. sr is shifted so the bit after the current one is always at a fixed index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr      <= '0;
         cnt     <= '0;
         s_out   <= 1'b0;
         s_valid <= 1'b0;
      end else if (accept) begin
         sr      <= p_in;
         cnt     <= '0;
         s_out   <= first_bit;
         s_valid <= 1'b1;
      end else if (state == SHIFT) begin
         if (cnt != LAST) begin
            sr    <= sr_shifted;
            cnt   <= cnt + CW'(1);
            s_out <= next_bit;
         end else begin
            s_out   <= 1'b0;
            s_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in serial-out transmitter, the transmit end of the 1-bit serial link whose receive end is the SIPO shift register.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out one bit per clock, with a qualifying valid strobe and a last-bit pulse.
- Supports back-to-back words with no idle gap, so a SIPO on the far end sees a continuous bit stream.

Parameters:
WIDTH, 4, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 is transmitted first.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  reset; asynchronous, active-low (rst=0 resets immediately, independent of clk).
p_in  input  WIDTH  parallel word; sampled only on the accepting edge.
load_valid  input  1  p_in holds a word to transmit.
load_ready  output  1  block can accept a word this cycle.
s_out  output  1  serial data bit (registered).
s_valid  output  1  s_out carries a valid bit this cycle (registered).
busy  output  1  shift in progress (state == SHIFT).
done  output  1  high during the cycle the last bit of a word is on s_out.

Behaviour:
- State machine: IDLE, SHIFT.
- Internal registers: shift register sr[WIDTH-1:0]; bit counter cnt of width $clog2(WIDTH), range 0..WIDTH-1.
- Reset (rst=0, asynchronous):
  - state=IDLE, sr=0, cnt=0, s_out=0, s_valid=0.
  - Therefore busy=0, done=0, load_ready=1 while in reset and after release.
- Acceptance occurs on a rising edge where load_valid && load_ready.
- load_ready = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1). Combinational from registers only; it never depends on load_valid.
- IDLE + acceptance:
  - sr <= p_in, cnt <= 0, state <= SHIFT.
  - First bit (p_in[WIDTH-1] if MSB_FIRST, else p_in[0]) appears on s_out with s_valid=1 in the cycle immediately after the accepting edge. Latency is 1 clock.
- IDLE, no acceptance: s_out=0, s_valid=0, sr and cnt hold.
- SHIFT, cnt < WIDTH-1:
  - Each edge advances one bit: cnt <= cnt+1.
  - s_out takes the next bit in order: MSB_FIRST bit WIDTH-1 down to 0; otherwise 0 up to WIDTH-1.
  - s_valid stays 1.
- SHIFT, cnt == WIDTH-1 (last bit on s_out):
  - done=1 for exactly this cycle (done = s_valid && cnt==WIDTH-1).
  - With acceptance on this edge: load the new word, cnt <= 0, stay in SHIFT. The new word's first bit follows the last bit on the next cycle, so s_valid stays continuously 1.
  - Without acceptance: state <= IDLE, s_valid <= 0, s_out <= 0.
- Each word produces exactly WIDTH consecutive s_valid cycles.
- p_in changes and load_valid assertions while load_ready=0 are ignored. The captured word is never corrupted.
- load_valid may be held high continuously. Every word is accepted exactly once, at each load_ready edge.
- Reset mid-word: transmission aborts at once, outputs go to their reset values, the partial word is discarded, and no done pulse occurs. The first load after rst returns high starts a fresh word at bit 0 of the sequence.
- No other outputs exist. No X may propagate on any output after reset.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with load_valid=1, p_in=4'hF -> s_out=0, s_valid=0, busy=0, done=0, load_ready=1 throughout; no word accepted.
2. Single word, WIDTH=4, MSB_FIRST=1: pulse load_valid one cycle with p_in=4'b1011 -> s_out=1,0,1,1 on the 4 cycles after the accepting edge. s_valid=1 and busy=1 for exactly those 4 cycles; done=1 only on the 4th; load_ready=0 on cycles 1-3; then s_out=0, s_valid=0.
3. Back-to-back: hold load_valid=1, present 4'b1001, then switch to 4'b0110 after the first acceptance -> 8 contiguous s_valid cycles carrying 1,0,0,1,0,1,1,0; done high on cycles 4 and 8 only; no gap cycle.
4. Ignore while busy: accept 4'b1100, then on cycle 2 drive p_in=4'b0011 with load_valid=1 -> output stays 1,1,0,0. 4'b0011 is accepted only at the cycle-4 edge (load_ready=1) and then transmitted as 0,0,1,1.
5. Reset mid-word: accept 4'b1010, drive rst=0 asynchronously mid-cycle after 2 bits -> s_out and s_valid drop to 0 immediately with no done. After release, load 4'b0111 -> 0,1,1,1.
6. WIDTH=8, MSB_FIRST=0: load 8'hA5 -> s_out=1,0,1,0,0,1,0,1 over 8 cycles; done on the 8th cycle.
